// File: rtl/config_loader_if.sv
// Word-stream handshake and latch-bank drive bundle for config_loader.
interface config_loader_if #(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned NUM_WORDS = 46
);
  localparam int unsigned IDX_W = 6;

  logic                 io_start;
  logic                 io_abort;
  logic                 io_word_valid;
  logic                 io_word_ready;
  logic [WORD_W-1:0]    io_word;
  logic [WORD_W-1:0]    io_d_out;
  logic [NUM_WORDS-1:0] io_configs_en;
  logic [IDX_W-1:0]     io_index;
  logic                 io_busy;
  logic                 io_done;

  modport master (
    output io_start, io_abort, io_word_valid, io_word,
    input  io_word_ready, io_d_out, io_configs_en, io_index, io_busy, io_done
  );

  modport slave (
    input  io_start, io_abort, io_word_valid, io_word,
    output io_word_ready, io_d_out, io_configs_en, io_index, io_busy, io_done
  );
endinterface

// File: rtl/config_loader.sv
// Sequences configuration words onto a level-sensitive latch bank with
// a guaranteed data setup cycle before and hold cycle after every enable.
module config_loader #(
  parameter int unsigned WORD_W       = 32,
  parameter int unsigned NUM_WORDS    = 46,
  parameter int unsigned PULSE_CYCLES = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  config_loader_if.slave io
);

  localparam int unsigned IDX_W = 6;
  localparam int unsigned CNT_W = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PULSE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_SETUP, S_STROBE, S_HOLD, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WORD_W-1:0]    data_q, data_d;
  logic [NUM_WORDS-1:0] en_q, en_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // Next state plus next value of every output; outputs are all flopped
  // so the latch enables cannot glitch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    data_d  = data_q;

    unique case (state_q)
      S_IDLE: begin
        if (io.io_start && !io.io_abort) begin
          state_d = S_WAIT;
          idx_d   = '0;
        end
      end
      S_WAIT: begin
        if (io.io_word_valid && ready_q) begin
          data_d  = io.io_word;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = '0;
        state_d = S_STROBE;
      end
      S_STROBE: begin
        if (cnt_q == LAST_CNT) state_d = S_HOLD;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      S_HOLD: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_WAIT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything, including a same-cycle handshake.
    if (io.io_abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      data_d  = data_q;
    end

    ready_d = (state_d == S_WAIT);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    en_d    = '0;
    if (state_d == S_STROBE) en_d[idx_d] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      en_q    <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      en_q    <= en_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign io.io_word_ready = ready_q;
  assign io.io_d_out      = data_q;
  assign io.io_configs_en = en_q;
  assign io.io_index      = idx_q;
  assign io.io_busy       = busy_q;
  assign io.io_done       = done_q;

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: one P=1 and one P=4 instance, with a
// latch-bank model and per-cycle enable monitors.
module tb_config_loader;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned NUM_WORDS = 46;

  logic clk = 1'b0;
  logic reset_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  config_loader_if #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS)) bus1 ();
  config_loader_if #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS)) bus4 ();

  config_loader #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .PULSE_CYCLES(1)) u_p1 (
    .clk(clk), .reset_n(reset_n), .io(bus1));
  config_loader #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .PULSE_CYCLES(4)) u_p4 (
    .clk(clk), .reset_n(reset_n), .io(bus4));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Latch-bank model, pulse counters and pulse-shape monitor
  logic [WORD_W-1:0]    lat1 [NUM_WORDS];
  int                   pulses1 [NUM_WORDS];
  logic [NUM_WORDS-1:0] prev_en1 = '0;
  logic [NUM_WORDS-1:0] prev_en4 = '0;
  logic [WORD_W-1:0]    prev_d4  = '0;
  int                   run4     = 0;
  int                   strobes4 = 0;

  always @(negedge clk) begin
    check("onehot0_p1", 64'($onehot0(bus1.io_configs_en)), 64'(1));
    check("onehot0_p4", 64'($onehot0(bus4.io_configs_en)), 64'(1));
    for (int k = 0; k < int'(NUM_WORDS); k++) begin
      if (bus1.io_configs_en[k]) begin
        lat1[k] = bus1.io_d_out;
        if (!prev_en1[k]) pulses1[k]++;
      end
    end
    prev_en1 = bus1.io_configs_en;
    if (bus4.io_configs_en != '0) begin
      if (prev_en4 == '0) begin
        check("p4_setup", 64'(prev_d4), 64'(bus4.io_d_out));
        run4 = 0;
      end
      run4++;
    end else if (prev_en4 != '0) begin
      check("p4_width", 64'(run4), 64'(4));
      check("p4_hold", 64'(bus4.io_d_out), 64'(prev_d4));
      strobes4++;
    end
    prev_en4 = bus4.io_configs_en;
    prev_d4  = bus4.io_d_out;
  end

  // One full load on the P=1 instance; optional 5-cycle valid gap before word gap_at
  task automatic load1(input logic [31:0] base, input int gap_at, input int exp_done, input string tag);
    int   cyc = 0, sent = 0, done_cyc = -1, n_done = 0, gap = 0;
    logic hs;
    for (int k = 0; k < int'(NUM_WORDS); k++) pulses1[k] = 0;
    bus1.io_word       = base;
    bus1.io_word_valid = 1'b1;
    bus1.io_start      = 1'b1;
    while (cyc < 600 && (done_cyc < 0 || cyc < done_cyc + 2)) begin
      hs = bus1.io_word_ready && bus1.io_word_valid;
      @(negedge clk);
      cyc++;
      bus1.io_start = (cyc == 20);
      if (hs) begin
        sent++;
        bus1.io_word = base + 32'(sent);
      end
      if (bus1.io_done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (sent == gap_at && bus1.io_word_ready) begin
        if (gap > 0) begin
          check({tag, "_gap_en"}, 64'(bus1.io_configs_en), 64'(0));
          check({tag, "_gap_idx"}, 64'(bus1.io_index), 64'(gap_at));
        end
        if (gap < 5) begin
          bus1.io_word_valid = 1'b0;
          gap++;
        end else begin
          bus1.io_word_valid = 1'b1;
        end
      end
    end
    bus1.io_word_valid = 1'b0;
    bus1.io_start      = 1'b0;
    check({tag, "_done_cyc"}, 64'(done_cyc), 64'(exp_done));
    check({tag, "_done_cnt"}, 64'(n_done), 64'(1));
    check({tag, "_busy_after"}, 64'(bus1.io_busy), 64'(0));
    check({tag, "_sent"}, 64'(sent), 64'(NUM_WORDS));
    for (int k = 0; k < int'(NUM_WORDS); k++) begin
      check($sformatf("%s_latch_%0d", tag, k), 64'(lat1[k]), 64'(base + 32'(k)));
      check($sformatf("%s_pulses_%0d", tag, k), 64'(pulses1[k]), 64'(1));
    end
  endtask

  int   sent, cyc, done_cyc;
  logic hs;

  initial begin
    reset_n = 1'b0;
    bus1.io_start = 1'b0; bus1.io_abort = 1'b0; bus1.io_word_valid = 1'b0; bus1.io_word = '0;
    bus4.io_start = 1'b0; bus4.io_abort = 1'b0; bus4.io_word_valid = 1'b0; bus4.io_word = '0;
    for (int k = 0; k < int'(NUM_WORDS); k++) begin
      lat1[k] = '0;
      pulses1[k] = 0;
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_en",    64'(bus1.io_configs_en), 64'(0));
    check("rst_d",     64'(bus1.io_d_out), 64'(0));
    check("rst_ready", 64'(bus1.io_word_ready), 64'(0));
    check("rst_busy",  64'(bus1.io_busy), 64'(0));
    check("rst_done",  64'(bus1.io_done), 64'(0));
    check("rst_idx",   64'(bus1.io_index), 64'(0));
    check("rst_en_p4", 64'(bus4.io_configs_en), 64'(0));

    // Asynchronous reset in the middle of a strobe
    bus1.io_start = 1'b1; bus1.io_word_valid = 1'b1; bus1.io_word = 32'h1234_5678;
    @(negedge clk);
    bus1.io_start = 1'b0;
    for (int i = 0; i < 10 && bus1.io_configs_en == '0; i++) @(negedge clk);
    check("mid_strobe_seen", 64'(bus1.io_configs_en), 64'(1));
    reset_n = 1'b0;
    #1;
    check("async_rst_en",   64'(bus1.io_configs_en), 64'(0));
    check("async_rst_d",    64'(bus1.io_d_out), 64'(0));
    check("async_rst_busy", 64'(bus1.io_busy), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    bus1.io_word_valid = 1'b0;
    @(negedge clk);
    check("post_rst_en",    64'(bus1.io_configs_en), 64'(0));
    check("post_rst_busy",  64'(bus1.io_busy), 64'(0));
    check("post_rst_ready", 64'(bus1.io_word_ready), 64'(0));
    check("post_rst_idx",   64'(bus1.io_index), 64'(0));
    check("post_rst_done",  64'(bus1.io_done), 64'(0));

    // Abort in IDLE, together with start: stays idle
    bus1.io_abort = 1'b1; bus1.io_start = 1'b1;
    @(negedge clk);
    check("idle_abort_busy",  64'(bus1.io_busy), 64'(0));
    check("idle_abort_ready", 64'(bus1.io_word_ready), 64'(0));
    @(negedge clk);
    check("idle_abort_busy2", 64'(bus1.io_busy), 64'(0));
    bus1.io_abort = 1'b0; bus1.io_start = 1'b0;
    @(negedge clk);

    load1(32'hA500_0000, -1, 185, "full_p1");
    load1(32'h5A00_0000, 3, 190, "gap_p1");

    // Abort during the strobe of word 10
    sent = 0;
    bus1.io_start = 1'b1; bus1.io_word_valid = 1'b1; bus1.io_word = 32'hC300_0000;
    for (int i = 0; i < 200 && !(bus1.io_index == 6'd10 && bus1.io_configs_en != '0); i++) begin
      hs = bus1.io_word_ready && bus1.io_word_valid;
      @(negedge clk);
      bus1.io_start = 1'b0;
      if (hs) begin
        sent++;
        bus1.io_word = 32'hC300_0000 + 32'(sent);
      end
    end
    check("abort_at_strobe10", 64'(bus1.io_configs_en), 64'(1) << 10);
    bus1.io_abort = 1'b1;
    @(negedge clk);
    bus1.io_abort = 1'b0;
    bus1.io_word_valid = 1'b0;
    check("abort_en",     64'(bus1.io_configs_en), 64'(0));
    check("abort_idx",    64'(bus1.io_index), 64'(0));
    check("abort_busy",   64'(bus1.io_busy), 64'(0));
    check("abort_ready",  64'(bus1.io_word_ready), 64'(0));
    check("abort_d",      64'(bus1.io_d_out), 64'(32'hC300_000A));
    check("abort_latch10", 64'(lat1[10]), 64'(32'hC300_000A));
    for (int i = 0; i < 5; i++) begin
      check("abort_no_done", 64'(bus1.io_done), 64'(0));
      @(negedge clk);
    end

    // Abort beats a same-cycle handshake
    bus1.io_start = 1'b1;
    @(negedge clk);
    bus1.io_start = 1'b0;
    check("restart_ready", 64'(bus1.io_word_ready), 64'(1));
    check("restart_busy",  64'(bus1.io_busy), 64'(1));
    check("restart_idx",   64'(bus1.io_index), 64'(0));
    bus1.io_word = 32'hDEAD_BEEF; bus1.io_word_valid = 1'b1; bus1.io_abort = 1'b1;
    @(negedge clk);
    bus1.io_abort = 1'b0; bus1.io_word_valid = 1'b0;
    check("abort_prio_d",    64'(bus1.io_d_out), 64'(32'hC300_000A));
    check("abort_prio_busy", 64'(bus1.io_busy), 64'(0));
    @(negedge clk);
    check("abort_prio_d2",   64'(bus1.io_d_out), 64'(32'hC300_000A));

    load1(32'h3C00_0000, -1, 185, "reload_p1");

    // Full load on the 4-cycle pulse instance
    sent = 0; cyc = 0; done_cyc = -1;
    bus4.io_start = 1'b1; bus4.io_word_valid = 1'b1; bus4.io_word = 32'h0F00_0000;
    while (cyc < 1000 && done_cyc < 0) begin
      hs = bus4.io_word_ready && bus4.io_word_valid;
      @(negedge clk);
      cyc++;
      bus4.io_start = 1'b0;
      if (hs) begin
        sent++;
        bus4.io_word = 32'h0F00_0000 + 32'(sent);
      end
      if (bus4.io_done) done_cyc = cyc;
    end
    bus4.io_word_valid = 1'b0;
    @(negedge clk);
    check("p4_done_cyc", 64'(done_cyc), 64'(323));
    check("p4_strobes",  64'(strobes4), 64'(NUM_WORDS));
    check("p4_last_d",   64'(bus4.io_d_out), 64'(32'h0F00_002D));
    check("p4_busy_after", 64'(bus4.io_busy), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/config_loader.md
# config_loader

Sequencer that drives the configuration latch bank of a LUT tile. It accepts a stream of 32-bit configuration words over a valid/ready handshake and presents each word on the shared data bus. It then pulses exactly one enable line per word, so word k lands in latch slice k. The enable timing guarantees data setup and hold around every strobe, because the downstream latches are level-sensitive and transparent while enabled.

## Interface
Parameters:
- WORD_W, 32, width of one configuration word and of the data bus
- NUM_WORDS, 46, number of latch slices / enable lines (total config bits = WORD_W*NUM_WORDS = 1472)
- PULSE_CYCLES, 1, cycles each enable stays high (legal range 1..15)

Ports:
- clk  input  1  single clock; all state changes on rising edge
- reset_n  input  1  reset, asynchronous, active-low
- io_start  input  1  begin a load of NUM_WORDS words; sampled only in IDLE
- io_abort  input  1  synchronous abort of a load in progress
- io_word_valid  input  1  io_word carries a word
- io_word_ready  output  1  loader accepts io_word this cycle
- io_word  input  WORD_W  configuration word, slice order 0 first
- io_d_out  output  WORD_W  data bus to latch bank
- io_configs_en  output  NUM_WORDS  one-hot or zero latch enables
- io_index  output  6  slice currently being loaded
- io_busy  output  1  load in progress (state != IDLE)
- io_done  output  1  one-cycle pulse, full load completed

## Operation
- Every output is driven directly from a flop. io_configs_en must never glitch.
- States: IDLE, WAIT, SETUP, STROBE, HOLD, DONE.
- IDLE: io_start=1 -> WAIT, index cleared to 0. io_start is ignored in every other state.
- WAIT: io_word_ready=1. On valid&ready, io_word is registered into io_d_out -> SETUP.
- SETUP: 1 cycle. io_d_out is stable and all enables are 0.
- STROBE: PULSE_CYCLES cycles with io_configs_en[index]=1 and all other bits 0. A pulse counter tracks the duration.
- HOLD: 1 cycle. Enables are 0 and io_d_out is unchanged.
- After HOLD: if index==NUM_WORDS-1 -> DONE, else index+1 -> WAIT.
- DONE: 1 cycle, io_done=1 -> IDLE.
- io_d_out changes only on a handshake accept. It keeps the last word after completion and after abort.
- io_abort=1 in any non-IDLE state -> IDLE at the next edge: enables 0, ready 0, no io_done pulse, index reset to 0.
  - An abort in STROBE ends the pulse early. Data is still held, so the slice keeps the word currently on the bus.
- io_abort has priority over the handshake in the same cycle; the word is not consumed.
- io_abort in IDLE has no effect. io_start and io_abort together in IDLE: abort wins, stay IDLE.
- At most one enable bit is high in any cycle. Enables are never high in IDLE, WAIT, SETUP, HOLD or DONE.

## Timing
- Reset (reset_n low, asynchronous): state IDLE, io_configs_en=0 immediately without waiting for a clock edge, io_d_out=0, io_word_ready=0, io_busy=0, io_done=0, io_index=0.
- After reset_n deasserts, the first state change is on the next rising edge.
- Reset mid-operation: enables drop combinationally with reset. The partial load is discarded; no done pulse.
- Word accepted at edge T: SETUP T..T+1, STROBE T+1..T+1+P, HOLD one cycle, io_word_ready high again one cycle after HOLD.
- Per-word cost: 3+PULSE_CYCLES cycles including the accept cycle, assuming valid is already high.
- Full load with continuous valid: NUM_WORDS*(3+P)+2 cycles from io_start to the io_done pulse (inclusive).
- Data setup to enable rise ≥1 cycle; data hold after enable fall ≥1 cycle.
- io_busy rises the cycle after io_start and falls the cycle after DONE.

## Test plan
- Reset: hold reset_n=0 mid-STROBE -> io_configs_en=0 in the same cycle; after release all outputs are 0 and the state is IDLE.
- Full load, P=1, words 0xA5000000+k with valid always high -> each io_configs_en[k] pulses once with io_d_out=0xA5000000+k. io_done fires 186 cycles after start, and a bench latch model holds all 1472 bits correct.
- Valid gaps: deassert valid for 5 cycles before word 3 -> loader waits in WAIT, enables stay 0, word 3 lands in slice 3.
- PULSE_CYCLES=4 -> each enable is high exactly 4 cycles, io_d_out stable 1 cycle before the rise and 1 cycle after the fall.
- Abort during STROBE of word 10 -> enables 0 next edge, no io_done, io_index=0. A fresh io_start reloads from slice 0.
- io_start while busy and io_abort in IDLE -> no effect. Assert one-hot-or-zero on io_configs_en in every cycle.
